// File: rtl/ntt_pkg.sv
// Shared constants and state encoding for the Barrett constant generator.
// Width helpers keep mu / dividend sizing tied to the modulus width.
package ntt_pkg;

  localparam int Q_W      = 48;
  localparam int MU_SHIFT = 2 * Q_W + 3;
  localparam int MU_W     = Q_W + 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int mu_w(input int n);
    return n + 5;
  endfunction

  function automatic int mu_shift(input int n);
    return 2 * n + 3;
  endfunction

endpackage

// File: rtl/barrett_mu_div_step.sv
// One radix-2 restoring division step: doubles the partial remainder and
// conditionally subtracts the modulus, emitting one quotient bit.
module div_step
  import ntt_pkg::*;
#(
  parameter int N = Q_W
) (
  input  logic [N-1:0] r,
  input  logic [N-1:0] qreg,
  output logic [N-1:0] r_nxt,
  output logic         qbit
);

  logic [N:0] t;

  // r < qreg keeps t below 2^(N+1); the low N bits of t - qreg are exact
  // whenever the subtraction is taken.
  always_comb begin
    t     = {r, 1'b0};
    qbit  = (t >= {1'b0, qreg});
    r_nxt = qbit ? (t[N-1:0] - qreg) : t[N-1:0];
  end

endmodule

// File: rtl/barrett_mu_gen.sv
// Sequential generator for mu = floor(2^(2N+3) / q), one quotient bit per clock.
// Define BARRETT_MU_REM_EN to also expose the final remainder on port rem.
module barrett_mu_gen
  import ntt_pkg::*;
#(
  parameter int N = Q_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [N-1:0] q,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [N+4:0] mu
`ifdef BARRETT_MU_REM_EN
  ,
  output logic [N-1:0] rem
`endif
);

  localparam int MW     = mu_w(N);
  localparam int R0_EXP = mu_shift(N) - MW;
  localparam int CW     = $clog2(MW);
  localparam logic [CW-1:0] CNT_LAST = CW'(MW - 1);
  // Starting remainder 2^(N-2) folds the 2^(2N+3) dividend into MW shifts.
  localparam logic [N-1:0] R_INIT = {{(N-1){1'b0}}, 1'b1} << R0_EXP;

  state_t        state, state_nxt;
  logic [N-1:0]  qreg;
  logic [N-1:0]  r;
  logic [N-1:0]  r_step;
  logic          qbit;
  logic [MW-2:0] quot;
  logic [CW-1:0] cnt;

  div_step #(.N(N)) u_step (
    .r     (r),
    .qreg  (qreg),
    .r_nxt (r_step),
    .qbit  (qbit)
  );

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = q[N-1] ? ST_RUN : ST_DONE;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
      qreg  <= '0;
      r     <= '0;
      quot  <= '0;
      cnt   <= '0;
      err   <= 1'b0;
      mu    <= '0;
`ifdef BARRETT_MU_REM_EN
      rem   <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            qreg <= q;
            if (q[N-1]) begin
              r    <= R_INIT;
              quot <= '0;
              cnt  <= '0;
              err  <= 1'b0;
            end else begin
              // Unnormalized modulus: report immediately, no iterations.
              err <= 1'b1;
              mu  <= '0;
`ifdef BARRETT_MU_REM_EN
              rem <= '0;
`endif
            end
          end
        end
        ST_RUN: begin
          r    <= r_step;
          quot <= {quot[MW-3:0], qbit};
          cnt  <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            mu  <= {quot, qbit};
`ifdef BARRETT_MU_REM_EN
            rem <= r_step;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_barrett_mu_gen.sv
// Self-checking bench for barrett_mu_gen: vector table, hand sequences and
// random moduli, all scored against a big-integer model of floor(2^99/q).
module tb_barrett_mu_gen;
  import ntt_pkg::*;

  localparam int N = Q_W;
  localparam logic [MU_SHIFT:0] DVD = {1'b1, {MU_SHIFT{1'b0}}};

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  q = '0;
  logic          busy, done, err;
  logic [MU_W-1:0] mu;
`ifdef BARRETT_MU_REM_EN
  logic [N-1:0]  rem;
`endif

  always #5 clk = ~clk;

  barrett_mu_gen #(.N(N)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .mu    (mu)
`ifdef BARRETT_MU_REM_EN
    ,
    .rem   (rem)
`endif
  );

  typedef struct {
    logic [N-1:0]    q;
    logic [MU_W-1:0] mu;
    logic [N-1:0]    rem;
    logic            err;
    int unsigned     done_cyc;
  } exp_t;

  typedef struct {
    logic [N-1:0]    q;
    logic [MU_W-1:0] mu;
    logic            err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;
  int unsigned busy_end = 0;
  int unsigned next_ok = 0;
  logic [MU_W-1:0] last_mu = '0;
  logic            last_err = 1'b0;
  logic [N-1:0]    last_rem = '0;
  logic            ovr = 1'b0;
  logic [MU_W-1:0] ovr_mu = '0;
  logic            ovr_err = 1'b0;

  function automatic logic [MU_W-1:0] model_mu(input logic [N-1:0] qq);
    return MU_W'(DVD / {{(MU_SHIFT + 1 - N){1'b0}}, qq});
  endfunction

  function automatic logic [N-1:0] model_rem(input logic [N-1:0] qq);
    return N'(DVD % {{(MU_SHIFT + 1 - N){1'b0}}, qq});
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // One clock: advance the reference model at the edge, then check outputs.
  task automatic tick();
    exp_t e;
    logic exp_busy, exp_done;
    @(posedge clk);
    cyc++;
    if (!rstn) begin
      sb.delete();
      busy_end = cyc;
      next_ok  = cyc + 1;
      last_mu  = '0;
      last_err = 1'b0;
      last_rem = '0;
    end else if (start && cyc >= next_ok) begin
      e.q = q;
      if (!q[N-1]) begin
        e.mu       = '0;
        e.rem      = '0;
        e.err      = 1'b1;
        e.done_cyc = cyc;
        busy_end   = cyc + 1;
      end else begin
        e.mu       = model_mu(q);
        e.rem      = model_rem(q);
        e.err      = 1'b0;
        e.done_cyc = cyc + N + 5;
        busy_end   = cyc + N + 6;
      end
      if (ovr) begin
        e.mu  = ovr_mu;
        e.err = ovr_err;
      end
      next_ok = busy_end + 1;
      sb.push_back(e);
    end
    #1;
    exp_busy = (cyc < busy_end);
    exp_done = (sb.size() > 0) && (sb[0].done_cyc == cyc);
    chk("busy", 128'(busy), 128'(exp_busy));
    chk("done", 128'(done), 128'(exp_done));
    if (exp_done) begin
      e = sb.pop_front();
      chk("mu", 128'(mu), 128'(e.mu));
      chk("err", 128'(err), 128'(e.err));
`ifdef BARRETT_MU_REM_EN
      chk("rem", 128'(rem), 128'(e.rem));
`endif
      last_mu  = e.mu;
      last_err = e.err;
      last_rem = e.rem;
    end else if (!exp_busy) begin
      chk("mu_hold", 128'(mu), 128'(last_mu));
      chk("err_hold", 128'(err), 128'(last_err));
`ifdef BARRETT_MU_REM_EN
      chk("rem_hold", 128'(rem), 128'(last_rem));
`endif
    end
  endtask

  task automatic run_one(input logic [N-1:0] qq);
    int guard;
    guard = 0;
    while (cyc + 1 < next_ok && guard < 200) begin
      tick();
      guard++;
    end
    q     = qq;
    start = 1'b1;
    tick();
    start = 1'b0;
    q     = ~qq;
    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      tick();
      guard++;
    end
  endtask

  function automatic logic [N-1:0] rand_norm();
    logic [63:0] rr;
    rr = {$urandom(), $urandom()};
    return {1'b1, rr[N-2:0]};
  endfunction

  initial begin
    vecs[0] = '{q: 48'hFFFFFFFFFDF1, mu: 53'h8000000001078,  err: 1'b0};
    vecs[1] = '{q: 48'h8000000003E9, mu: 53'h0FFFFFFFFF82E0, err: 1'b0};
    vecs[2] = '{q: 48'h800000000000, mu: 53'h10000000000000, err: 1'b0};
    vecs[3] = '{q: 48'hFFFFFFFFFFFF, mu: 53'h8000000000008,  err: 1'b0};
    vecs[4] = '{q: 48'h7FFFFFFFFFFF, mu: 53'h0,              err: 1'b1};

    // Reset state
    repeat (3) tick();
    rstn = 1'b1;
    repeat (2) tick();

    // Directed table
    for (int i = 0; i < 5; i++) begin
      ovr     = 1'b1;
      ovr_mu  = vecs[i].mu;
      ovr_err = vecs[i].err;
      run_one(vecs[i].q);
      ovr     = 1'b0;
    end
    repeat (5) tick();

    // start held high with q changing every cycle
    start = 1'b1;
    for (int i = 0; i < 3 * (N + 7) + 4; i++) begin
      q = rand_norm();
      tick();
    end
    start = 1'b0;
    repeat (N + 8) tick();

    // Reset in the middle of an iteration run
    run_one(48'hFFFFFFFFFDF1);
    q     = 48'h8000000003E9;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    rstn = 1'b0;
    tick();
    chk("rst_mu", 128'(mu), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    rstn = 1'b1;
    tick();
    chk("post_rst_done", 128'(done), 128'(0));
    run_one(48'hFFFFFFFFFFFF);

    // Random normalized moduli
    for (int i = 0; i < 1000; i++) begin
      run_one(rand_norm());
    end
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
